// File: rtl/register_file_sb.sv
// Register file with two async read ports, one sync write port, an optional PC-mapped top register and a per-register busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining RF_BYPASS_EN.
module register_file_sb #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int PC_MAPPED = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        a1,
    input  logic [ADDR_W-1:0]        a2,
    input  logic [ADDR_W-1:0]        a3,
    input  logic [DATA_W-1:0]        wd3,
    input  logic                     wen,
    input  logic [DATA_W-1:0]        r7,
    input  logic                     lock_req,
    input  logic [ADDR_W-1:0]        lock_addr,
    output logic [DATA_W-1:0]        rd1,
    output logic [DATA_W-1:0]        rd2,
    output logic                     busy1,
    output logic                     busy2,
    output logic [(1<<ADDR_W)-1:0]   busy_vec
);

    localparam int                DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wr_ok;
    logic              lk_ok;

    function automatic logic is_pc(input logic [ADDR_W-1:0] a);
        return (PC_MAPPED != 0) && (a == PC_ADDR);
    endfunction

    assign wr_ok = wen && !is_pc(a3);
    assign lk_ok = lock_req && !is_pc(lock_addr);

    // Lock is applied after the write-clear so a same-address collision leaves the register reserved.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) busy_d[a3] = 1'b0;
        if (lk_ok) busy_d[lock_addr] = 1'b1;
        if (PC_MAPPED != 0) busy_d[DEPTH-1] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy_q <= '0;
        end else begin
            if (wr_ok) mem[a3] <= wd3;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    always_comb begin
        rd1   = is_pc(a1) ? r7 : mem[a1];
        rd2   = is_pc(a2) ? r7 : mem[a2];
        busy1 = busy_q[a1];
        busy2 = busy_q[a2];
`ifdef RF_BYPASS_EN
        // Forward the in-flight writeback so a consumer need not wait for the edge.
        if (wr_ok && (a3 == a1)) begin
            rd1   = wd3;
            busy1 = 1'b0;
        end
        if (wr_ok && (a3 == a2)) begin
            rd2   = wd3;
            busy2 = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed, table-driven bench for register_file_sb (DATA_W=8, ADDR_W=3, PC_MAPPED=1).
module tb_register_file_sb;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] a1, a2, a3, lock_addr;
    logic [7:0] wd3, r7;
    logic       wen, lock_req;
    logic [7:0] rd1, rd2;
    logic       busy1, busy2;
    logic [7:0] busy_vec;

    int n_checks = 0;
    int n_fail   = 0;

    register_file_sb #(.DATA_W(8), .ADDR_W(3), .PC_MAPPED(1)) dut (
        .clk(clk), .reset(reset),
        .a1(a1), .a2(a2), .a3(a3), .wd3(wd3), .wen(wen), .r7(r7),
        .lock_req(lock_req), .lock_addr(lock_addr),
        .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2), .busy_vec(busy_vec)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [2:0] a1, a2, a3;
        logic [7:0] wd3;
        logic       wen;
        logic [7:0] r7;
        logic       lock_req;
        logic [2:0] lock_addr;
        logic [7:0] e_rd1, e_rd2;
        logic       e_b1, e_b2;
        logic [7:0] e_bv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] va1, input logic [2:0] va2,
                                input logic [2:0] va3, input logic [7:0] vwd3, input logic vwen,
                                input logic [7:0] vr7, input logic vlk, input logic [2:0] vla,
                                input logic [7:0] erd1, input logic [7:0] erd2,
                                input logic eb1, input logic eb2, input logic [7:0] ebv);
        vec_t v;
        v.a1 = va1; v.a2 = va2; v.a3 = va3; v.wd3 = vwd3; v.wen = vwen;
        v.r7 = vr7; v.lock_req = vlk; v.lock_addr = vla;
        v.e_rd1 = erd1; v.e_rd2 = erd2; v.e_b1 = eb1; v.e_b2 = eb2; v.e_bv = ebv;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        a1 = 3'd0; a2 = 3'd7; a3 = 3'd0; wd3 = 8'h00; wen = 1'b0;
        r7 = 8'hA5; lock_req = 1'b0; lock_addr = 3'd0;

        // Expected outputs are sampled before the edge on which the vector's inputs are committed.
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(3'd0, 3'd0, 3'(i), 8'(i), 1'b1, 8'hA5, 1'b0, 3'd0,
                              8'h00, 8'h00, 1'b0, 1'b0, 8'h00));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(3'(i), 3'(7 - i), 3'd0, 8'h00, 1'b0, 8'hA5, 1'b0, 3'd0,
                              (i == 7) ? 8'hA5 : 8'(i), (i == 0) ? 8'hA5 : 8'(7 - i),
                              1'b0, 1'b0, 8'h00));
        // PC protect
        vecs.push_back(mk(3'd7, 3'd0, 3'd7, 8'h3C, 1'b1, 8'h10, 1'b0, 3'd0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(3'd7, 3'd0, 3'd0, 8'h00, 1'b0, 8'h10, 1'b1, 3'd7, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(3'd7, 3'd7, 3'd0, 8'h00, 1'b0, 8'h10, 1'b0, 3'd0, 8'h10, 8'h10, 1'b0, 1'b0, 8'h00));
        // Scoreboard
        vecs.push_back(mk(3'd3, 3'd3, 3'd0, 8'h00, 1'b0, 8'hA5, 1'b1, 3'd3, 8'h03, 8'h03, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(3'd3, 3'd3, 3'd0, 8'h00, 1'b0, 8'hA5, 1'b0, 3'd0, 8'h03, 8'h03, 1'b1, 1'b1, 8'h08));
        vecs.push_back(mk(3'd0, 3'd0, 3'd3, 8'h55, 1'b1, 8'hA5, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h08));
        vecs.push_back(mk(3'd3, 3'd0, 3'd0, 8'h00, 1'b0, 8'hA5, 1'b0, 3'd0, 8'h55, 8'h00, 1'b0, 1'b0, 8'h00));
        // Same-address collision: lock wins, data still written
        vecs.push_back(mk(3'd0, 3'd0, 3'd2, 8'h77, 1'b1, 8'hA5, 1'b1, 3'd2, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(3'd2, 3'd0, 3'd0, 8'h00, 1'b0, 8'hA5, 1'b0, 3'd0, 8'h77, 8'h00, 1'b1, 1'b0, 8'h04));
        // Different addresses in one cycle, then re-lock, then write of a non-busy register
        vecs.push_back(mk(3'd0, 3'd5, 3'd2, 8'h12, 1'b1, 8'hA5, 1'b1, 3'd5, 8'h00, 8'h05, 1'b0, 1'b0, 8'h04));
        vecs.push_back(mk(3'd2, 3'd5, 3'd0, 8'h00, 1'b0, 8'hA5, 1'b1, 3'd5, 8'h12, 8'h05, 1'b0, 1'b1, 8'h20));
        vecs.push_back(mk(3'd0, 3'd5, 3'd6, 8'h66, 1'b1, 8'hA5, 1'b0, 3'd0, 8'h00, 8'h05, 1'b0, 1'b1, 8'h20));
        vecs.push_back(mk(3'd6, 3'd5, 3'd0, 8'h00, 1'b0, 8'hA5, 1'b0, 3'd0, 8'h66, 8'h05, 1'b0, 1'b1, 8'h20));
        // Bypass window: R4 = 04 and busy while its writeback is in flight
        vecs.push_back(mk(3'd4, 3'd0, 3'd0, 8'h00, 1'b0, 8'hA5, 1'b1, 3'd4, 8'h04, 8'h00, 1'b0, 1'b0, 8'h20));
`ifdef RF_BYPASS_EN
        vecs.push_back(mk(3'd4, 3'd0, 3'd4, 8'h99, 1'b1, 8'hA5, 1'b0, 3'd0, 8'h99, 8'h00, 1'b0, 1'b0, 8'h30));
`else
        vecs.push_back(mk(3'd4, 3'd0, 3'd4, 8'h99, 1'b1, 8'hA5, 1'b0, 3'd0, 8'h04, 8'h00, 1'b1, 1'b0, 8'h30));
`endif
        vecs.push_back(mk(3'd4, 3'd0, 3'd0, 8'h00, 1'b0, 8'hA5, 1'b0, 3'd0, 8'h99, 8'h00, 1'b0, 1'b0, 8'h20));

        // Power-on reset state
        #3;
        chk("por_busy_vec", busy_vec, 8'h00);
        chk("por_rd1_r0", rd1, 8'h00);
        chk("por_rd2_pc", rd2, 8'hA5);
        @(negedge clk);
        reset = 1'b1;

        // Mid-run async reset: populate state, then pull reset between edges
        @(negedge clk);
        wen = 1'b1; a3 = 3'd1; wd3 = 8'hEE; lock_req = 1'b1; lock_addr = 3'd2;
        @(negedge clk);
        wen = 1'b0; lock_req = 1'b0; a1 = 3'd1;
        #2;
        chk("pre_rst_rd1", rd1, 8'hEE);
        chk("pre_rst_busy_vec", busy_vec, 8'h04);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a1 = 3'(i);
            #1;
            chk($sformatf("rst_rd1_a%0d", i), rd1, (i == 7) ? 8'hA5 : 8'h00);
        end
        chk("rst_busy_vec", busy_vec, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        a1 = 3'd0;

        foreach (vecs[k]) begin
            @(negedge clk);
            a1 = vecs[k].a1; a2 = vecs[k].a2; a3 = vecs[k].a3; wd3 = vecs[k].wd3;
            wen = vecs[k].wen; r7 = vecs[k].r7;
            lock_req = vecs[k].lock_req; lock_addr = vecs[k].lock_addr;
            #5;
            chk($sformatf("v%0d_rd1", k), rd1, vecs[k].e_rd1);
            chk($sformatf("v%0d_rd2", k), rd2, vecs[k].e_rd2);
            chk($sformatf("v%0d_busy1", k), {7'd0, busy1}, {7'd0, vecs[k].e_b1});
            chk($sformatf("v%0d_busy2", k), {7'd0, busy2}, {7'd0, vecs[k].e_b2});
            chk($sformatf("v%0d_busy_vec", k), busy_vec, vecs[k].e_bv);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
